// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences the shared datapath through FETCH/DECODE/EXEC/MEM/WB, drives
// the ALU control class (aluop) and resolves branches from the ALU flags.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       alu_zero,
    input  logic       alu_lsb,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [1:0] aluop,
    output logic [1:0] alusrc_a,
    output logic [1:0] alusrc_b,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic       instret,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    state_t r_state;
    state_t w_next;
    logic   w_legal;
    logic   w_taken;

    // Opcode legality check used at DECODE
    always_comb begin
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: w_legal = 1'b1;
            default:                                w_legal = 1'b0;
        endcase
    end

    // Branch decision from ALU flags; func3 010/011 never taken
    always_comb begin
        case (func3)
            3'b000:         w_taken = alu_zero;
            3'b001:         w_taken = ~alu_zero;
            3'b100, 3'b110: w_taken = alu_lsb;
            3'b101, 3'b111: w_taken = ~alu_lsb;
            default:        w_taken = 1'b0;
        endcase
    end

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE:                   w_next = S_MEM;
                    OPC_BRANCH, OPC_JAL, OPC_JALR:         w_next = S_FETCH;
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: w_next = S_WB;
                    default:                               w_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_next = (opcode == OPC_STORE) ? S_FETCH : S_WB;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Output decode; every output is held at 0 while rst is high
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        aluop        = 2'b00;
        alusrc_a     = 2'b00;
        alusrc_b     = 2'b00;
        reg_we       = 1'b0;
        wb_sel       = 2'b00;
        illegal      = 1'b0;
        instret      = 1'b0;
        state        = 3'd0;
        if (!rst) begin
            state = r_state;
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                S_DECODE: begin
                    alusrc_a = 2'b01;
                    alusrc_b = 2'b01;
                end
                S_EXEC: begin
                    case (opcode)
                        OPC_OP: begin
                            aluop = 2'b10;
                        end
                        OPC_OPIMM: begin
                            alusrc_b = 2'b01;
                            aluop    = 2'b01;
                        end
                        OPC_LUI: begin
                            alusrc_a = 2'b10;
                            alusrc_b = 2'b01;
                        end
                        OPC_AUIPC: begin
                            alusrc_a = 2'b01;
                            alusrc_b = 2'b01;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            alusrc_b = 2'b01;
                        end
                        OPC_BRANCH: begin
                            aluop   = 2'b11;
                            pc_we   = 1'b1;
                            pc_sel  = w_taken ? 2'b01 : 2'b00;
                            instret = 1'b1;
                        end
                        OPC_JAL: begin
                            pc_we   = 1'b1;
                            pc_sel  = 2'b01;
                            reg_we  = 1'b1;
                            wb_sel  = 2'b10;
                            instret = 1'b1;
                        end
                        OPC_JALR: begin
                            alusrc_b = 2'b01;
                            pc_we    = 1'b1;
                            pc_sel   = 2'b10;
                            reg_we   = 1'b1;
                            wb_sel   = 2'b10;
                            instret  = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OPC_STORE);
                    if ((opcode == OPC_STORE) && mem_ready) begin
                        pc_we   = 1'b1;
                        instret = 1'b1;
                    end
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    wb_sel  = (opcode == OPC_LOAD) ? 2'b01 : 2'b00;
                    pc_we   = 1'b1;
                    instret = 1'b1;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. It sequences the shared datapath (PC, IR, register file, ALU, ALUOut register, unified memory port) through FETCH/DECODE/EXEC/MEM/WB. It drives the 2-bit `aluop` consumed by the ALU control decoder: 00 = add, 01 = I-type, 10 = R-type, 11 = branch compare. It also resolves branches from ALU flags.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: IR[6:0].
- `func3` in 3: IR[14:12], used for the branch decision only.
- `alu_zero` in 1: ALU result == 0.
- `alu_lsb` in 1: ALU result bit 0 (slt/sltu outcome).
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = store.
- `mem_addr_sel` out 1: 0 = PC, 1 = ALUOut.
- `ir_we` out 1: IR load.
- `pc_we` out 1: PC load.
- `pc_sel` out 2: 00 = PC+4, 01 = ALUOut, 10 = ALU result & ~1.
- `aluop` out 2: to the ALU control decoder.
- `alusrc_a` out 2: 00 = rs1, 01 = PC, 10 = zero.
- `alusrc_b` out 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `reg_we` out 1: register file write.
- `wb_sel` out 2: 00 = ALUOut, 01 = memory data, 10 = PC+4.
- `illegal` out 1: sticky trap flag.
- `instret` out 1: one-cycle pulse per retired instruction.
- `state` out 3: debug state code. FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.

## Operation
- Outputs are decoded from `state`. `ir_we`, `pc_sel` for branches, and every exit from a wait state also depend on `mem_ready` and the ALU flags. Every strobe not listed for a state is 0.
- **FETCH**
  - Drives `mem_req`=1, `mem_addr_sel`=0.
  - `ir_we` = `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**
  - ALU computes PC+imm: `alusrc_a`=01, `alusrc_b`=01, `aluop`=00. The datapath latches the result into ALUOut every cycle.
  - Next state is EXEC for a legal opcode.
  - Any opcode outside {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011} goes to TRAP.
- **EXEC**, per opcode:
  - OP: a=00, b=00, aluop=10. Go to WB.
  - OP-IMM: a=00, b=01, aluop=01. Go to WB.
  - LUI: a=10, b=01, aluop=00. Go to WB.
  - AUIPC: a=01, b=01, aluop=00. Go to WB.
  - LOAD and STORE: a=00, b=01, aluop=00. Go to MEM.
  - BRANCH:
    - a=00, b=00, aluop=11.
    - taken = beq: `alu_zero`; bne: !`alu_zero`; blt/bltu: `alu_lsb`; bge/bgeu: !`alu_lsb`. func3 010/011 are treated as not-taken.
    - `pc_we`=1, `pc_sel` = taken ? 01 : 00.
    - `instret`=1, then go to FETCH.
  - JAL: `pc_we`=1, `pc_sel`=01, `reg_we`=1, `wb_sel`=10, `instret`=1. Go to FETCH.
  - JALR:
    - a=00, b=01, aluop=00.
    - `pc_we`=1, `pc_sel`=10, `reg_we`=1, `wb_sel`=10, `instret`=1.
    - Go to FETCH.
- **MEM**
  - Drives `mem_req`=1, `mem_addr_sel`=1, `mem_we` = (opcode == STORE).
  - Waits for `mem_ready`.
  - LOAD goes to WB.
  - STORE retires in the completing cycle (`pc_we`=1, `pc_sel`=00, `instret`=1), then goes to FETCH.
- **WB**
  - `reg_we`=1.
  - `wb_sel` = 01 for LOAD, otherwise 00.
  - `pc_we`=1, `pc_sel`=00, `instret`=1.
  - Go to FETCH.
- **TRAP**
  - `illegal`=1. All strobes stay 0, including `mem_req`.
  - Stays in TRAP until `rst`.
- Opcode and func3 are read from the IR, which is stable from DECODE until the next FETCH completes.

## Timing
- `rst`=1 at an edge puts the FSM in FETCH. This applies from any state, including mid-request in FETCH, MEM or TRAP.
- While `rst` is high, every output is forced to 0: `state` reads 0, `illegal`=0. The first `mem_req` appears in the cycle after `rst` falls.
- Memory handshake:
  - `mem_req`, `mem_we` and `mem_addr_sel` stay constant from assertion until the cycle in which `mem_ready`=1. That cycle completes the transfer.
  - `mem_ready` with `mem_req`=0 is ignored.
- Minimum latency with zero-wait memory:
  - Branch, JAL, JALR: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- `instret` pulses exactly once per instruction, in the same cycle as its `pc_we`. `pc_we` never asserts outside a retire cycle.

## Test plan
- **R-type timing:** reset, then ADD (opcode 0110111 → use 0110011), `mem_ready` held at 1 → states 0,1,2,4. EXEC shows aluop=10, a=00, b=00. WB shows `reg_we`=1, `wb_sel`=00, `pc_we`=1, `pc_sel`=00, `instret`=1. Back in FETCH on cycle 5.
- **Load with waits:** LW with `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEM → total 10 cycles. `mem_addr_sel`/`mem_we`/`mem_req` stable throughout each wait. WB `wb_sel`=01.
- **Branch sweep:** BNE with `alu_zero`=0 → `pc_sel`=01. BGEU with `alu_lsb`=1 → `pc_sel`=00. Both with `pc_we`=1 and aluop=11 in EXEC, 3 cycles each.
- **Jumps:** JALR → EXEC shows `pc_sel`=10, `reg_we`=1, `wb_sel`=10, `instret`=1, next state FETCH.
- **Illegal opcode:** opcode 1110011 → DECODE goes to TRAP, `illegal`=1 and all strobes 0 for 20 cycles. `rst` pulse → `illegal`=0, `state`=0.
- **Reset mid-MEM:** STORE waiting in MEM, assert `rst` for 1 cycle → no `pc_we`/`instret`. FETCH with `mem_addr_sel`=0 the cycle after release.
